// File: rtl/priority_drain_encoder.sv
// priority_drain_encoder
// Accepts a WIDTH-bit request vector over valid/ready and reports the index of
// every set bit, one beat per cycle, highest index first. An all-zero vector
// produces a single beat flagged with out_zero.
// Build option: define PDE_LOW_FIRST_EN to drain lowest set bit first instead.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; a producer holding valid keeps its data stable until that edge, and
// out_valid/out_* never change while waiting for out_ready (except under rst).
module priority_drain_encoder #(
  parameter int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_zero,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ZERO  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;

  logic [IDX_W-1:0] sel_idx;
  logic [WIDTH-1:0] sel_onehot;
  logic             pend_single;
  logic             accept;
  logic             out_hs;

  // Pick the bit to report next from the registered pending vector.
  always_comb begin
    sel_idx    = '0;
    sel_onehot = '0;
`ifdef PDE_LOW_FIRST_EN
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_idx       = IDX_W'(i);
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
      end
    end
`else
    for (int i = 0; i < WIDTH; i++) begin
      if (pending_q[i]) begin
        sel_idx       = IDX_W'(i);
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
      end
    end
`endif
  end

  // Exactly one bit left means the current beat is the final one.
  assign pend_single = (pending_q != '0) &&
                       ((pending_q & (pending_q - {{(WIDTH-1){1'b0}}, 1'b1})) == '0);

  // Output decode: registers only, no path from in_* to out_*.
  always_comb begin
    out_valid = 1'b0;
    out_idx   = '0;
    out_last  = 1'b0;
    out_zero  = 1'b0;
    case (state_q)
      ST_DRAIN: begin
        out_valid = 1'b1;
        out_idx   = sel_idx;
        out_last  = pend_single;
      end
      ST_ZERO: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_zero  = 1'b1;
      end
      default: ;
    endcase
  end

  assign out_hs    = out_valid & out_ready;
  // Ready when idle, or when the final beat leaves this cycle (no bubble).
  assign in_ready  = ~rst & ((state_q == ST_IDLE) | (out_hs & out_last));
  assign accept    = in_valid & in_ready;
  assign dbg_state = state_q;

  // Next-state logic: retire beats, then let a new accept override.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      ST_DRAIN: begin
        if (out_hs) begin
          if (out_last) begin
            pending_d = '0;
            state_d   = ST_IDLE;
          end else begin
            pending_d = pending_q & ~sel_onehot;
          end
        end
      end
      ST_ZERO: begin
        if (out_hs) state_d = ST_IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      if (in_req != '0) begin
        pending_d = in_req;
        state_d   = ST_DRAIN;
      end else begin
        pending_d = '0;
        state_d   = ST_ZERO;
      end
    end
  end

  // State and pending vector registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_priority_drain_encoder.sv
// Self-checking bench for priority_drain_encoder (WIDTH=8).
// Reference: each accepted vector expands into its list of beats, queued in
// drain order; outputs are compared against the head of that queue.
module tb_priority_drain_encoder;

  localparam int W     = 8;
  localparam int IDX_W = $clog2(W);
  localparam int BW    = IDX_W + 2;  // {zero, last, idx}

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_req;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_zero;
  logic [1:0]       dbg_state;

  int total = 0;
  int bad   = 0;

  logic [BW-1:0] exp_q[$];

  priority_drain_encoder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_req    (in_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_zero  (out_zero),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: list the set bits in drain order; a zero vector gives one beat.
  task automatic push_vec(input logic [W-1:0] req);
    int idx_list[$];
    for (int i = 0; i < W; i++) if (req[i]) idx_list.push_back(i);
`ifndef PDE_LOW_FIRST_EN
    idx_list.reverse();
`endif
    if (idx_list.size() == 0) begin
      exp_q.push_back({1'b1, 1'b1, {IDX_W{1'b0}}});
    end else begin
      foreach (idx_list[k])
        exp_q.push_back({1'b0, (k == idx_list.size() - 1), IDX_W'(idx_list[k])});
    end
  endtask

  // Driver + checker for one clock cycle: drive after the falling edge,
  // sample just after, then update the reference for the coming rising edge.
  task automatic cycle(input logic v, input logic [W-1:0] req, input logic ordy);
    logic          exp_ov, exp_ir;
    logic [BW-1:0] front;
    @(negedge clk);
    in_valid  = v;
    in_req    = req;
    out_ready = ordy;
    #1;
    exp_ov = (exp_q.size() != 0);
    front  = exp_ov ? exp_q[0] : '0;
    exp_ir = !exp_ov || (ordy && front[IDX_W]);
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    if (exp_ov) chk("beat{zero,last,idx}", 32'({out_zero, out_last, out_idx}), 32'(front));
    if (exp_ov && ordy) void'(exp_q.pop_front());
    if (v && exp_ir) push_vec(req);
  endtask

  // Three reset cycles with in_valid high, then release.
  task automatic do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_req    = W'($urandom);
      out_ready = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      if (c > 0) begin
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_fields", 32'({out_zero, out_last, out_idx}), 32'd0);
      end
    end
    exp_q.delete();
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_req    = '0;
    out_ready = 1'b0;

    // Reset behaviour
    do_reset();

    // Multi-bit vector drained with out_ready high
    cycle(1'b1, 8'b1001_0100, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // All-zero vector
    cycle(1'b1, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // Backpressure: beat held, in_ready low, in_req changes ignored
    cycle(1'b1, 8'b0000_0011, 1'b0);
    for (int c = 0; c < 4; c++) cycle(1'b1, 8'hff, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // Back-to-back accept on the last beat
    cycle(1'b1, 8'h01, 1'b1);
    cycle(1'b1, 8'h80, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // Reset in the middle of a drain
    cycle(1'b1, 8'b1001_0100, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    do_reset();
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [W-1:0] r;
      r = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      cycle(1'($urandom_range(0, 1)), r, ($urandom_range(0, 3) != 0));
    end

    // Drain whatever remains, bounded
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) cycle(1'b0, 8'h00, 1'b1);
    chk("final_drain_empty", 32'(exp_q.size()), 32'd0);
    cycle(1'b0, 8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
